// File: rtl/dcsa_result_checker_if.sv
// Result bus between the duplicated carry-select adder and its checker:
// input beat handshake, checked output beat, error reporting and clear.
interface dcsa_result_checker_if #(
    parameter int WIDTH = 60,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_invert;
    logic             papb;
    logic             pab;
    logic             pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s_out;
    logic             err_dual;
    logic             err_par_in;
    logic             err_par_sum;
    logic [2:0]       err_sticky;
    logic [CNT_W-1:0] err_count;
    logic             alarm;
    logic             err_clear;

    modport master (
        output in_valid, s, s_invert, papb, pab, pc, out_ready, err_clear,
        input  in_ready, out_valid, s_out, err_dual, err_par_in, err_par_sum,
               err_sticky, err_count, alarm
    );

    modport slave (
        input  in_valid, s, s_invert, papb, pab, pc, out_ready, err_clear,
        output in_ready, out_valid, s_out, err_dual, err_par_in, err_par_sum,
               err_sticky, err_count, alarm
    );
endinterface

// File: rtl/dcsa_result_checker.sv
// Checks dual-rail and parity consistency of each adder result, forwards the sum
// through a 2-stage valid/ready pipeline and tracks errors for fault management.
module dcsa_result_checker #(
    parameter int WIDTH        = 60,
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    dcsa_result_checker_if.slave bus
);
    typedef enum logic [1:0] {ST_OK, ST_ERR, ST_ALARM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    logic             r_v1, r_v2;
    logic [WIDTH-1:0] r_s1, r_si1, r_s2;
    logic             r_papb1, r_pab1, r_pc1;
    logic [2:0]       r_err2;

    logic             w_ld1, w_ld2, w_beat2, w_count_evt;
    logic [2:0]       w_err;

    logic [CNT_W-1:0] r_count, w_cnt_base, w_cnt_nxt;
    logic [2:0]       r_sticky, w_sticky_nxt;
    state_t           r_state, w_state_base, w_state_nxt;
    logic             r_alarm;

    // Reset asserts asynchronously and is released two clocks later, in sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_ld2       = !r_v2 || bus.out_ready;
    assign w_ld1       = !r_v1 || w_ld2;
    assign w_beat2     = w_ld2 && r_v1;

    // {par_sum, par_in, dual} of the beat sitting in stage 1
    assign w_err[0]    = |(~(r_s1 ^ r_si1));
    assign w_err[1]    = r_papb1 ^ r_pab1;
    assign w_err[2]    = (^r_s1) ^ r_pab1 ^ r_pc1;
    assign w_count_evt = w_beat2 && (|w_err);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_s1    <= '0;
            r_si1   <= '0;
            r_papb1 <= 1'b0;
            r_pab1  <= 1'b0;
            r_pc1   <= 1'b0;
            r_s2    <= '0;
            r_err2  <= '0;
        end else begin
            if (w_ld1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1    <= bus.s;
                    r_si1   <= bus.s_invert;
                    r_papb1 <= bus.papb;
                    r_pab1  <= bus.pab;
                    r_pc1   <= bus.pc;
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2   <= r_s1;
                    r_err2 <= w_err;
                end
            end
        end
    end

    // Clear is applied to the base values first so a colliding error beat still counts.
    always_comb begin
        w_cnt_base   = bus.err_clear ? '0 : r_count;
        w_sticky_nxt = bus.err_clear ? '0 : r_sticky;
        w_state_base = bus.err_clear ? ST_OK : r_state;
        w_cnt_nxt    = w_cnt_base;
        w_state_nxt  = w_state_base;
        if (w_count_evt) begin
            w_sticky_nxt = w_sticky_nxt | w_err;
            if (w_cnt_base != CNT_MAX) w_cnt_nxt = w_cnt_base + CNT_W'(1);
            case (w_state_base)
                ST_OK, ST_ERR: w_state_nxt = (w_cnt_nxt >= THRESH) ? ST_ALARM : ST_ERR;
                default:       w_state_nxt = ST_ALARM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= ST_OK;
            r_count  <= '0;
            r_sticky <= '0;
            r_alarm  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_cnt_nxt;
            r_sticky <= w_sticky_nxt;
            r_alarm  <= (w_state_nxt == ST_ALARM);
        end
    end

    assign bus.in_ready    = w_rst_n && w_ld1;
    assign bus.out_valid   = r_v2;
    assign bus.s_out       = r_s2;
    assign bus.err_dual    = r_err2[0];
    assign bus.err_par_in  = r_err2[1];
    assign bus.err_par_sum = r_err2[2];
    assign bus.err_sticky  = r_sticky;
    assign bus.err_count   = r_count;
    assign bus.alarm       = r_alarm;
endmodule
